simple_bus: RTL and testbench

Point-to-point simple bus link between one leader (processor thread) and one follower (memory thread). It carries a 16-bit address over an 8-bit shared address path in two beats, then moves one 8-bit data byte with a `dataValid` handshake. The block contains the leader FSM, the follower FSM and the resolved shared bus. It sits between a processor-side request port and a memory-side access port.

---
 rtl/simple_bus_if.sv | 42 ++++
 rtl/simple_bus.sv | 146 ++++++++++++++
 tb/tb_simple_bus.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/simple_bus_if.sv
// Signal bundle for the simple_bus link: processor request port, memory access port
// and the resolved shared-bus observation lines.
interface simple_bus_if;
   logic        req_access;
   logic        req_read;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        req_wdata_rdy;
   logic [7:0]  rsp_rdata;
   logic        rsp_done;
   logic        busy;

   logic [15:0] mem_addr;
   logic [7:0]  mem_rdata;
   logic        mem_rdata_avail;
   logic [7:0]  mem_wdata;
   logic        mem_we;

   logic        bus_start;
   logic        bus_read;
   logic        bus_data_valid;
   logic [7:0]  bus_address;
   logic [7:0]  bus_data;

   // Environment side: drives requests and memory responses.
   modport master (
      output req_access, req_read, req_addr, req_wdata, req_wdata_rdy,
      output mem_rdata, mem_rdata_avail,
      input  rsp_rdata, rsp_done, busy,
      input  mem_addr, mem_wdata, mem_we,
      input  bus_start, bus_read, bus_data_valid, bus_address, bus_data
   );

   // Link side: the simple_bus block itself.
   modport slave (
      input  req_access, req_read, req_addr, req_wdata, req_wdata_rdy,
      input  mem_rdata, mem_rdata_avail,
      output rsp_rdata, rsp_done, busy,
      output mem_addr, mem_wdata, mem_we,
      output bus_start, bus_read, bus_data_valid, bus_address, bus_data
   );
endinterface

// File: rtl/simple_bus.sv
// Leader/follower link moving a 16-bit address in two 8-bit beats and one data byte
// over a shared bus; each FSM drives its share of the bus, resolved by OR (0 = undriven).
module simple_bus (
   input  logic         clock,
   input  logic         resetN,
   simple_bus_if.slave  bus
);

   typedef enum logic [1:0] {MA, MB, MC, MD} lead_state_e;
   typedef enum logic [1:0] {SA, SB, SC, SD} foll_state_e;

   lead_state_e lead_q, lead_d;
   foll_state_e foll_q, foll_d;
   logic [7:0]  lo_addr_q, lo_addr_d;
   logic        read_q, read_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        done_q, done_d;
   logic [15:0] mem_addr_q, mem_addr_d;

   logic        l_start, l_read, l_valid;
   logic [7:0]  l_address, l_data;
   logic        f_valid;
   logic [7:0]  f_data;
   logic        bus_start, bus_read, bus_valid;
   logic [7:0]  bus_address, bus_data;
   logic        mem_we;

   // Leader bus drivers; acceptance is gated by resetN so the bus stays quiet in reset.
   // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      l_start   = 1'b0;
      l_read    = 1'b0;
      l_valid   = 1'b0;
      l_address = 8'h00;
      l_data    = 8'h00;
      case (lead_q)
         MA: if (bus.req_access && resetN) begin
            l_start   = 1'b1;
            l_address = bus.req_addr[15:8];
         end
         MB: begin
            l_address = lo_addr_q;
            l_read    = read_q;
         end
         MD: if (bus.req_wdata_rdy) begin
            l_valid = 1'b1;
            l_data  = bus.req_wdata;
         end
         default: ;
      endcase
   end

   always_comb begin
      f_valid = (foll_q == SC) && bus.mem_rdata_avail;
      f_data  = f_valid ? bus.mem_rdata : 8'h00;
   end

   // Data drivers are exclusive by state (MD vs SC), so OR-resolution never merges two owners.
   assign bus_start   = l_start;
   assign bus_read    = l_read;
   assign bus_address = l_address;
   assign bus_valid   = l_valid | f_valid;
   assign bus_data    = l_data | f_data;

   always_comb begin
      lead_d    = lead_q;
      lo_addr_d = lo_addr_q;
      read_d    = read_q;
      rdata_d   = rdata_q;
      done_d    = 1'b0;
      case (lead_q)
         MA: if (l_start) begin
            lo_addr_d = bus.req_addr[7:0];
            read_d    = bus.req_read;
            lead_d    = MB;
         end
         MB: lead_d = read_q ? MC : MD;
         MC: if (bus_valid) begin
            rdata_d = bus_data;
            done_d  = 1'b1;
            lead_d  = MA;
         end
         MD: if (l_valid) begin
            done_d = 1'b1;
            lead_d = MA;
         end
         default: lead_d = MA;
      endcase
   end

   always_comb begin
      foll_d     = foll_q;
      mem_addr_d = mem_addr_q;
      mem_we     = 1'b0;
      case (foll_q)
         SA: if (bus_start) begin
            mem_addr_d[15:8] = bus_address;
            foll_d           = SB;
         end
         SB: begin
            mem_addr_d[7:0] = bus_address;
            foll_d          = bus_read ? SC : SD;
         end
         SC: if (f_valid) foll_d = SA;
         SD: if (bus_valid) begin
            mem_we = 1'b1;
            foll_d = SA;
         end
         default: foll_d = SA;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         lead_q     <= MA;
         foll_q     <= SA;
         lo_addr_q  <= 8'h00;
         read_q     <= 1'b0;
         rdata_q    <= 8'h00;
         done_q     <= 1'b0;
         mem_addr_q <= 16'h0000;
      end else begin
         lead_q     <= lead_d;
         foll_q     <= foll_d;
         lo_addr_q  <= lo_addr_d;
         read_q     <= read_d;
         rdata_q    <= rdata_d;
         done_q     <= done_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   assign bus.rsp_rdata      = rdata_q;
   assign bus.rsp_done       = done_q;
   assign bus.busy           = (lead_q != MA);
   assign bus.mem_addr       = mem_addr_q;
   assign bus.mem_wdata      = bus_data;
   assign bus.mem_we         = mem_we;
   assign bus.bus_start      = bus_start;
   assign bus.bus_read       = bus_read;
   assign bus.bus_data_valid = bus_valid;
   assign bus.bus_address    = bus_address;
   assign bus.bus_data       = bus_data;

endmodule

// File: tb/tb_simple_bus.sv
// Directed bench for simple_bus: inputs change 1 ns after each rising edge and
// outputs are checked 1 ns later, well away from the next edge.
module tb_simple_bus;

   logic clock;
   logic resetN;
   int   checks = 0;
   int   errors = 0;
   int   we_count = 0;
   int   start_count = 0;
   int   base_we;
   int   base_start;

   simple_bus_if bif ();

   simple_bus dut (
      .clock  (clock),
      .resetN (resetN),
      .bus    (bif.slave)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   always @(negedge clock) begin
      if (bif.mem_we)    we_count++;
      if (bif.bus_start) start_count++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bif.req_access      = 1'b0;
      bif.req_read        = 1'b0;
      bif.req_addr        = 16'h0000;
      bif.req_wdata       = 8'h00;
      bif.req_wdata_rdy   = 1'b0;
      bif.mem_rdata       = 8'h00;
      bif.mem_rdata_avail = 1'b0;
   endtask

   initial begin
      idle_inputs();
      resetN = 1'b0;
      bif.req_access = 1'b1;
      #3;
      check("rst_busy",     bif.busy, 0);
      check("rst_done",     bif.rsp_done, 0);
      check("rst_we",       bif.mem_we, 0);
      check("rst_mem_addr", bif.mem_addr, 0);
      check("rst_rdata",    bif.rsp_rdata, 0);
      check("rst_start",    bif.bus_start, 0);
      check("rst_address",  bif.bus_address, 0);
      check("rst_valid",    bif.bus_data_valid, 0);
      bif.req_access = 1'b0;
      #9 resetN = 1'b1;

      // Write 0x5A to 0x1234, data ready in cycle 2
      cyc();
      bif.req_access = 1'b1; bif.req_read = 1'b0; bif.req_addr = 16'h1234; bif.req_wdata = 8'h5A;
      #1;
      check("w1_c0_start", bif.bus_start, 1);
      check("w1_c0_addr",  bif.bus_address, 8'h12);
      cyc(); bif.req_access = 1'b0; #1;
      check("w1_c1_addr",  bif.bus_address, 8'h34);
      check("w1_c1_read",  bif.bus_read, 0);
      check("w1_c1_busy",  bif.busy, 1);
      cyc(); bif.req_wdata_rdy = 1'b1; #1;
      check("w1_c2_we",    bif.mem_we, 1);
      check("w1_c2_maddr", bif.mem_addr, 16'h1234);
      check("w1_c2_wdata", bif.mem_wdata, 8'h5A);
      cyc(); bif.req_wdata_rdy = 1'b0; #1;
      check("w1_c3_done",  bif.rsp_done, 1);
      check("w1_c3_busy",  bif.busy, 0);
      check("w1_c3_we",    bif.mem_we, 0);
      cyc(); #1;
      check("w1_c4_done",  bif.rsp_done, 0);

      // Read 0xABCD, avail delayed 3 cycles
      cyc();
      bif.req_access = 1'b1; bif.req_read = 1'b1; bif.req_addr = 16'hABCD; #1;
      check("r1_c0_addr", bif.bus_address, 8'hAB);
      cyc(); bif.req_access = 1'b0; #1;
      check("r1_c1_addr", bif.bus_address, 8'hCD);
      check("r1_c1_read", bif.bus_read, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(); bif.mem_rdata = 8'hC3; bif.mem_rdata_avail = 1'b0; #1;
         check("r1_wait_valid", bif.bus_data_valid, 0);
         check("r1_wait_busy",  bif.busy, 1);
      end
      cyc(); bif.mem_rdata_avail = 1'b1; #1;
      check("r1_avail_valid", bif.bus_data_valid, 1);
      check("r1_avail_data",  bif.bus_data, 8'hC3);
      check("r1_avail_maddr", bif.mem_addr, 16'hABCD);
      check("r1_avail_rdata", bif.rsp_rdata, 8'h00);
      cyc(); bif.mem_rdata_avail = 1'b0; #1;
      check("r1_rdata", bif.rsp_rdata, 8'hC3);
      check("r1_done",  bif.rsp_done, 1);
      check("r1_busy",  bif.busy, 0);
      cyc(); #1;
      check("r1_done_once", bif.rsp_done, 0);

      // Write 0x77 to 0x00F0 with data ready held low for 4 cycles
      base_we = we_count;
      cyc();
      bif.req_access = 1'b1; bif.req_read = 1'b0; bif.req_addr = 16'h00F0; bif.req_wdata = 8'h77; #1;
      cyc(); bif.req_access = 1'b0; #1;
      for (int i = 0; i < 4; i++) begin
         cyc(); #1;
         check("w2_stall_we",    bif.mem_we, 0);
         check("w2_stall_data",  bif.bus_data, 0);
         check("w2_stall_valid", bif.bus_data_valid, 0);
      end
      cyc(); bif.req_wdata_rdy = 1'b1; #1;
      check("w2_we",    bif.mem_we, 1);
      check("w2_maddr", bif.mem_addr, 16'h00F0);
      check("w2_wdata", bif.mem_wdata, 8'h77);
      cyc(); bif.req_wdata_rdy = 1'b0; #1;
      check("w2_done", bif.rsp_done, 1);
      check("w2_busy", bif.busy, 0);
      cyc(); #1;
      check("w2_idle_we",  bif.mem_we, 0);
      check("w2_we_count", we_count - base_we, 1);

      // Back-to-back: read 0x0001 then write 0xFF to 0x0001
      cyc();
      bif.req_access = 1'b1; bif.req_read = 1'b1; bif.req_addr = 16'h0001; #1;
      cyc(); bif.req_access = 1'b0; #1;
      cyc(); bif.mem_rdata = 8'h3C; bif.mem_rdata_avail = 1'b1; #1;
      check("bb_rvalid", bif.bus_data_valid, 1);
      cyc();
      bif.mem_rdata_avail = 1'b0;
      bif.req_access = 1'b1; bif.req_read = 1'b0; bif.req_addr = 16'h0001; bif.req_wdata = 8'hFF; #1;
      check("bb_done",   bif.rsp_done, 1);
      check("bb_start",  bif.bus_start, 1);
      check("bb_rdata",  bif.rsp_rdata, 8'h3C);
      check("bb_haddr",  bif.bus_address, 8'h00);
      cyc(); bif.req_access = 1'b0; #1;
      check("bb_laddr",  bif.bus_address, 8'h01);
      check("bb_read",   bif.bus_read, 0);
      cyc(); bif.req_wdata_rdy = 1'b1; #1;
      check("bb_we",     bif.mem_we, 1);
      check("bb_maddr",  bif.mem_addr, 16'h0001);
      check("bb_wdata",  bif.mem_wdata, 8'hFF);
      cyc(); bif.req_wdata_rdy = 1'b0; #1;
      check("bb_wdone",  bif.rsp_done, 1);

      // Reset during MC/SC aborts the read
      base_we = we_count;
      cyc();
      bif.req_access = 1'b1; bif.req_read = 1'b1; bif.req_addr = 16'h4321; #1;
      cyc(); bif.req_access = 1'b0; #1;
      cyc(); #1;
      check("ar_busy_pre", bif.busy, 1);
      #2 resetN = 1'b0;
      #1;
      check("ar_busy",  bif.busy, 0);
      check("ar_maddr", bif.mem_addr, 0);
      check("ar_rdata", bif.rsp_rdata, 0);
      check("ar_valid", bif.bus_data_valid, 0);
      bif.mem_rdata = 8'h55; bif.mem_rdata_avail = 1'b1;
      cyc(); #1;
      check("ar_hold_done",  bif.rsp_done, 0);
      check("ar_hold_valid", bif.bus_data_valid, 0);
      bif.mem_rdata_avail = 1'b0;
      #2 resetN = 1'b1;
      cyc(); #1;
      check("ar_post_done", bif.rsp_done, 0);
      check("ar_no_we",     we_count - base_we, 0);

      // Fresh read after reset: 0x0202 returns 0x99 immediately
      cyc();
      bif.req_access = 1'b1; bif.req_read = 1'b1; bif.req_addr = 16'h0202; #1;
      cyc(); bif.req_access = 1'b0; #1;
      cyc(); bif.mem_rdata = 8'h99; bif.mem_rdata_avail = 1'b1; #1;
      check("fr_maddr", bif.mem_addr, 16'h0202);
      cyc(); bif.mem_rdata_avail = 1'b0; #1;
      check("fr_rdata", bif.rsp_rdata, 8'h99);
      check("fr_done",  bif.rsp_done, 1);

      // req_access toggled while busy is ignored
      base_start = start_count;
      base_we = we_count;
      cyc();
      bif.req_access = 1'b1; bif.req_read = 1'b0; bif.req_addr = 16'h0F0F; bif.req_wdata = 8'h11; #1;
      check("tg_c0_start", bif.bus_start, 1);
      cyc(); bif.req_access = 1'b1; #1;
      check("tg_c1_start", bif.bus_start, 0);
      cyc(); bif.req_access = 1'b0; #1;
      check("tg_c2_start", bif.bus_start, 0);
      cyc(); bif.req_access = 1'b1; #1;
      check("tg_c3_start", bif.bus_start, 0);
      cyc(); bif.req_access = 1'b0; bif.req_wdata_rdy = 1'b1; #1;
      check("tg_we",    bif.mem_we, 1);
      check("tg_maddr", bif.mem_addr, 16'h0F0F);
      check("tg_wdata", bif.mem_wdata, 8'h11);
      cyc(); bif.req_wdata_rdy = 1'b0; #1;
      check("tg_done", bif.rsp_done, 1);
      cyc(); #1;
      check("tg_start_count", start_count - base_start, 1);
      check("tg_we_count",    we_count - base_we, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
